inst_fetch: RTL

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/rv32i_pkg.sv | 14 +
 rtl/inst_fetch_pc.sv | 35 +++
 rtl/inst_fetch.sv | 128 ++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end definitions: fetch FSM state type, reset PC default
// and the sequential PC increment.
package rv32i_pkg;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_HOLD   = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0100_0000;
    localparam logic [31:0] PC_INC           = 32'd4;

endpackage : rv32i_pkg

// File: rtl/inst_fetch_pc.sv
// Program counter register with its next-PC mux (reset / +4 / word-aligned
// redirect). Redirect wins over sequential increment.
module inst_fetch_pc
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_inc,
    input  logic        pc_redirect,
    input  logic [29:0] redirect_word,
    output logic [31:0] pc
);

    logic [31:0] pc_d;

    always_comb begin
        pc_d = pc;
        if (pc_redirect) begin
            pc_d = {redirect_word, 2'b00};
        end else if (pc_inc) begin
            pc_d = pc + PC_INC;  // wraps modulo 2^32
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_d;
        end
    end

endmodule : inst_fetch_pc

// File: rtl/inst_fetch.sv
// Instruction fetch stage: FETCH/HOLD/HALTED FSM, instruction hold register,
// misaligned-redirect pulse. Optional perf counter under FETCH_PERF_CNT_EN.
module inst_fetch
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic         imem_req,
    output logic [31:0]  imem_addr,
    input  logic         imem_ack,
    input  logic [31:0]  imem_rdata,
    output logic [31:0]  instr,
    output logic [31:0]  instr_pc,
    output logic         instr_valid,
    input  logic         instr_ready,
    input  logic         halt,
    input  logic         redirect,
    input  logic [31:0]  redirect_pc,
    output logic         halted,
    output logic         misalign_err,
    output logic [31:0]  fetch_count,
    output fetch_state_e fsm_state
);

    // Decoder handshake: an instruction transfers in any cycle where
    // instr_valid and instr_ready are both high; instr/instr_pc hold until then.
    fetch_state_e state_q, state_d;
    logic         handshake;
    logic         capture;
    logic         pc_inc;
    logic         pc_redirect;
    logic [31:0]  pc;

    assign handshake = instr_valid & instr_ready;

    always_comb begin
        state_d     = state_q;
        imem_req    = 1'b0;
        capture     = 1'b0;
        pc_inc      = 1'b0;
        pc_redirect = 1'b0;
        case (state_q)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (redirect) begin
                    pc_redirect = 1'b1;  // same-cycle ack is discarded
                end else if (imem_ack) begin
                    capture = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (handshake && halt) begin
                    state_d = ST_HALTED;
                end else if (redirect) begin
                    pc_redirect = 1'b1;
                    state_d     = ST_FETCH;
                end else if (handshake) begin
                    pc_inc  = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_FETCH;
            instr        <= '0;
            instr_pc     <= '0;
            instr_valid  <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            state_q      <= state_d;
            misalign_err <= pc_redirect & (|redirect_pc[1:0]);
            if (capture) begin
                instr       <= imem_rdata;
                instr_pc    <= pc;
                instr_valid <= 1'b1;
            end else if (state_d != ST_HOLD) begin
                instr_valid <= 1'b0;
            end
        end
    end

    inst_fetch_pc #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_inc        (pc_inc),
        .pc_redirect   (pc_redirect),
        .redirect_word (redirect_pc[31:2]),
        .pc            (pc)
    );

    assign imem_addr = pc;
    assign halted    = (state_q == ST_HALTED);
    assign fsm_state = state_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] count_q;
    logic        accept;

    assign accept = (state_q == ST_HOLD) & handshake & ~halt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (accept && (count_q != 32'hFFFF_FFFF)) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign fetch_count = count_q;
`else
    assign fetch_count = '0;
`endif

endmodule : inst_fetch
